// File: rtl/riscv_mem_responder_pkg.sv
// Shared types, constants and helpers for the riscv_mem_responder memory block.
package mem_resp_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned DEFAULT_DEPTH = 16384;
  localparam int unsigned MAX_READ_LAT  = 4;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_RANGE = 2'd1,
    FLT_ALIGN = 2'd2
  } fault_e;

  // Byte-lane merge: enabled lanes come from new_w, the rest from old_w.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input strobe_t strb);
    word_t res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  function automatic fault_e classify(input logic [31:0] addr, input logic [32:0] limit);
    fault_e flt;
    if (addr[1:0] != 2'b00) begin
      flt = FLT_ALIGN;
    end else if ({1'b0, addr} >= limit) begin
      flt = FLT_RANGE;
    end else begin
      flt = FLT_NONE;
    end
    return flt;
  endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Instruction and data port bus between the CPU and riscv_mem_responder.
interface riscv_mem_responder_if;
  import mem_resp_pkg::*;

  logic        instr_read;
  logic [31:0] instr_addr;
  word_t       instr_out;
  logic        data_read;
  logic        data_write;
  strobe_t     data_wstrb;
  logic [31:0] data_addr;
  word_t       data_in;
  word_t       data_out;

  modport master (
    output instr_read, instr_addr, data_read, data_write, data_wstrb, data_addr, data_in,
    input  instr_out, data_out
  );

  modport slave (
    input  instr_read, instr_addr, data_read, data_write, data_wstrb, data_addr, data_in,
    output instr_out, data_out
  );

endinterface

// File: rtl/riscv_mem_responder_rd_pipe.sv
// Read-return pipeline: LAT stages of {valid, word}; the last stage only
// loads on a valid word, so the output holds between returned reads.
module mem_rd_pipe
  import mem_resp_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  word_t in_word,
  output word_t out_word
);

  logic [LAT-1:0] stage_v_s;
  word_t          stage_w_s [LAT];
  word_t          word_q    [LAT];
  word_t          word_d    [LAT];

  assign stage_w_s[0] = in_word;
  for (genvar i = 1; i < LAT; i++) begin : g_fwd
    assign stage_w_s[i] = word_q[i-1];
  end

  if (LAT > 1) begin : g_chain
    logic [LAT-2:0] vld_q;
    logic [LAT-2:0] vld_d;

    always_comb begin
      vld_d = stage_v_s[LAT-2:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= {(LAT-1){1'b0}};
      end else begin
        vld_q <= vld_d;
      end
    end

    assign stage_v_s = {vld_q, in_valid};
  end else begin : g_single
    assign stage_v_s = in_valid;
  end

  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      if (stage_v_s[i]) begin
        word_d[i] = stage_w_s[i];
      end else begin
        word_d[i] = word_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) begin
      if (rst) begin
        word_q[i] <= 32'h0;
      end else begin
        word_q[i] <= word_d[i];
      end
    end
  end

  assign out_word = word_q[LAT-1];

endmodule

// File: rtl/riscv_mem_responder.sv
// Shared instruction/data word memory with registered read pipelines and address
// fault counting. Define MEM_RAW_BYPASS_EN to forward same-cycle stores to data loads.
module riscv_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ERR_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_mem_responder_if.slave  bus,
  output logic                  addr_err,
  output logic [ERR_W-1:0]      err_count
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned LAT_EFF = (READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT :
                                    ((READ_LAT < 1) ? 1 : READ_LAT);
  localparam logic [32:0]      ADDR_LIMIT = 33'(DEPTH) * 33'(WORD_BYTES);
  localparam logic [ERR_W-1:0] CNT_MAX    = {ERR_W{1'b1}};

  word_t            mem_q [DEPTH];
  logic [IDX_W-1:0] i_idx_s;
  logic [IDX_W-1:0] d_idx_s;
  fault_e           i_flt_s;
  fault_e           d_flt_s;
  logic             i_fault_s;
  logic             d_fault_s;
  logic             wr_en_s;
  word_t            d_word_s;
  word_t            i_rdata_s;
  word_t            d_rdata_s;
  word_t            instr_word_s;
  word_t            data_word_s;
  logic [1:0]       inc_s;
  logic [ERR_W+1:0] cnt_sum_s;
  logic             addr_err_d;
  logic             addr_err_q;
  logic [ERR_W-1:0] err_count_d;
  logic [ERR_W-1:0] err_count_q;

  always_comb begin
    i_idx_s   = bus.instr_addr[IDX_W+1:2];
    d_idx_s   = bus.data_addr[IDX_W+1:2];
    i_flt_s   = classify(bus.instr_addr, ADDR_LIMIT);
    d_flt_s   = classify(bus.data_addr, ADDR_LIMIT);
    i_fault_s = bus.instr_read && (i_flt_s != FLT_NONE);
    d_fault_s = (bus.data_read || bus.data_write) && (d_flt_s != FLT_NONE);
    wr_en_s   = bus.data_write && (d_flt_s == FLT_NONE) && !rst;
  end

  // The instruction port always sees the pre-store word.
  always_comb begin
`ifdef MEM_RAW_BYPASS_EN
    d_word_s = wr_en_s ? merge_bytes(mem_q[d_idx_s], bus.data_in, bus.data_wstrb)
                       : mem_q[d_idx_s];
`else
    d_word_s = mem_q[d_idx_s];
`endif
    i_rdata_s = (i_flt_s == FLT_NONE) ? mem_q[i_idx_s] : 32'h0;
    d_rdata_s = (d_flt_s == FLT_NONE) ? d_word_s : 32'h0;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && bus.data_wstrb[b]) begin
        mem_q[d_idx_s][8*b +: 8] <= bus.data_in[8*b +: 8];
      end
    end
  end

  always_comb begin
    inc_s       = {1'b0, i_fault_s} + {1'b0, d_fault_s};
    cnt_sum_s   = {2'b00, err_count_q} + {{ERR_W{1'b0}}, inc_s};
    addr_err_d  = i_fault_s || d_fault_s;
    if (cnt_sum_s > {2'b00, CNT_MAX}) begin
      err_count_d = CNT_MAX;
    end else begin
      err_count_d = cnt_sum_s[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err_q  <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
    end else begin
      addr_err_q  <= addr_err_d;
      err_count_q <= err_count_d;
    end
  end

  mem_rd_pipe #(.LAT(LAT_EFF)) u_instr_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.instr_read),
    .in_word  (i_rdata_s),
    .out_word (instr_word_s)
  );

  mem_rd_pipe #(.LAT(LAT_EFF)) u_data_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.data_read),
    .in_word  (d_rdata_s),
    .out_word (data_word_s)
  );

  assign bus.instr_out = instr_word_s;
  assign bus.data_out  = data_word_s;
  assign addr_err      = addr_err_q;
  assign err_count     = err_count_q;

endmodule
